chip8_mem_arbiter: RTL and testbench

- Two-port arbiter and burst sequencer in front of the single-port CHIP-8 memory: 4 KiB, 8-bit, one write enable, read data registered one cycle after the address.
- Port A serves the CPU core: opcode fetch, FX55/FX65 load/store and FX33 BCD writes.
- Port B serves the draw engine: DXYN sprite row reads.
- The block serialises requests, generates incrementing burst addresses, and routes read data back with per-beat valid strobes.

---
 rtl/chip8_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: two-port arbiter and incrementing-burst sequencer in
// front of the single-port CHIP-8 memory. Port A serves the CPU core, port B
// serves the sprite draw engine. Read data is returned one cycle after each
// issued address, qualified by a per-port valid strobe.
module chip8_mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  // Port A (CPU core)
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [LEN_W-1:0]  len_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  // Port B (draw engine)
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [LEN_W-1:0]  len_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  // Memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {IDLE, ISSUE} state_e;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  state_e              state_q;
  port_e               owner_q;     // port that owns the burst in flight
  port_e               last_q;      // port granted most recently (round-robin)
  logic                burst_we_q;  // burst in flight is a write
  logic [LEN_W-1:0]    beat_cnt_q;  // beats still to issue after the current one
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                gnt_a_q;
  logic                gnt_b_q;
  logic                rvalid_a_q;
  logic                rvalid_b_q;

  logic                elig_a;
  logic                elig_b;
  logic                arb_slot;
  logic                grant_d;
  port_e               sel_port_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [LEN_W-1:0]    sel_len_d;
  logic [DATA_W-1:0]   sel_wdata_d;
  logic                issuing_read;

  // Arbitration: pick a winner among eligible ports and mux its attributes.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sel_port_d  = PORT_A;
    elig_a      = req_a && !gnt_a_q;  // a port's req is ignored during its own gnt cycle
    elig_b      = req_b && !gnt_b_q;
    arb_slot    = (state_q == IDLE) || (beat_cnt_q == '0);
    grant_d     = arb_slot && (elig_a || elig_b);
    if (elig_a && elig_b) begin
      if (FIXED_PRIO) sel_port_d = PORT_A;
      else            sel_port_d = (last_q == PORT_A) ? PORT_B : PORT_A;
    end else if (elig_b) begin
      sel_port_d = PORT_B;
    end
    sel_we_d    = (sel_port_d == PORT_B) ? we_b    : we_a;
    sel_addr_d  = (sel_port_d == PORT_B) ? addr_b  : addr_a;
    sel_len_d   = (sel_port_d == PORT_B) ? len_b   : len_a;
    sel_wdata_d = (sel_port_d == PORT_B) ? wdata_b : wdata_a;
  end

  // A read beat is on the memory bus whenever a read burst is issuing.
  assign issuing_read = (state_q == ISSUE) && !burst_we_q;

  // Burst sequencer FSM with registered grant, valid and memory outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= PORT_A;
      last_q      <= PORT_B;  // makes port A win the first tie
      burst_we_q  <= 1'b0;
      beat_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
    end else begin
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      // Memory returns data one cycle after the address; mirror that delay.
      rvalid_a_q <= issuing_read && (owner_q == PORT_A);
      rvalid_b_q <= issuing_read && (owner_q == PORT_B);

      if ((state_q == ISSUE) && (beat_cnt_q != '0)) begin
        // Mid-burst: next sequential address, wrapping at the top of memory.
        mem_addr_q <= mem_addr_q + ADDR_ONE;
        beat_cnt_q <= beat_cnt_q - LEN_ONE;
        mem_we_q   <= 1'b0;
      end else if (grant_d) begin
        // Idle or final beat with a pending request: start the next burst
        // immediately so back-to-back bursts have no bubble.
        state_q     <= ISSUE;
        owner_q     <= sel_port_d;
        last_q      <= sel_port_d;
        burst_we_q  <= sel_we_d;
        beat_cnt_q  <= sel_we_d ? '0 : sel_len_d;  // writes are always one beat
        mem_addr_q  <= sel_addr_d;
        mem_we_q    <= sel_we_d;
        mem_wdata_q <= sel_wdata_d;
        gnt_a_q     <= (sel_port_d == PORT_A);
        gnt_b_q     <= (sel_port_d == PORT_B);
      end else begin
        // Nothing to do: park, keeping the last address on the bus.
        state_q    <= IDLE;
        beat_cnt_q <= '0;
        mem_we_q   <= 1'b0;
      end
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign rdata_a   = mem_rdata;
  assign rdata_b   = mem_rdata;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == ISSUE);

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: scoreboard bench for chip8_mem_arbiter. Expected read
// bytes are queued per port from a reference memory image when a request is
// driven, and popped as rvalid beats appear. A second instance checks the
// fixed-priority configuration.
module tb_chip8_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [11:0] addr_a = '0, addr_b = '0;
  logic [3:0]  len_a = '0, len_b = '0;
  logic [7:0]  wdata_a = '0, wdata_b = '0;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0]  rdata_a, rdata_b;
  logic [11:0] mem_addr;
  logic        mem_we, busy;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  // Fixed-priority instance signals
  logic        fp_req_a = 1'b0, fp_req_b = 1'b0;
  logic        fp_gnt_a, fp_gnt_b, fp_rvalid_a, fp_rvalid_b, fp_mem_we, fp_busy;
  logic [7:0]  fp_rdata_a, fp_rdata_b, fp_mem_wdata;
  logic [11:0] fp_mem_addr;

  always #5 clk = ~clk;

  chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .LEN_W(4), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .len_a(len_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .len_b(len_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .LEN_W(4), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req_a(fp_req_a), .we_a(1'b0), .addr_a(12'h100), .len_a(4'd3), .wdata_a(8'h00),
    .gnt_a(fp_gnt_a), .rvalid_a(fp_rvalid_a), .rdata_a(fp_rdata_a),
    .req_b(fp_req_b), .we_b(1'b0), .addr_b(12'h180), .len_b(4'd0), .wdata_b(8'h00),
    .gnt_b(fp_gnt_b), .rvalid_b(fp_rvalid_b), .rdata_b(fp_rdata_b),
    .mem_addr(fp_mem_addr), .mem_we(fp_mem_we), .mem_wdata(fp_mem_wdata), .mem_rdata(8'h00),
    .busy(fp_busy)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------- memory models
  function automatic logic [7:0] init_byte(input int a);
    case (a)
      'h000:   return 8'hF0;
      'h001:   return 8'h90;
      'h200:   return 8'h12;
      'h201:   return 8'h34;
      default: return 8'(a) ^ 8'h5A;
    endcase
  endfunction

  logic [7:0] mem     [0:4095];   // memory the DUT drives
  logic [7:0] ref_mem [0:4095];   // reference image the bench predicts from
  bit         mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_byte(i);
      mem_loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------------------------------------------------------- monitor
  typedef struct { bit port; int cyc; } gnt_ev_t;

  int          cyc = 0;
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  gnt_ev_t     gnt_log[$];
  logic [11:0] addr_log[$];
  int          rva_cyc[$];
  int          we_cnt = 0, we_cyc = -1, rv_cnt_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [7:0] e;
    if (rvalid_a === 1'b1) begin
      rv_cnt_a++;
      rva_cyc.push_back(cyc);
      if (exp_a.size() == 0) check("rvalid_a_unexpected", 32'(rvalid_a), 32'd0);
      else begin e = exp_a.pop_front(); check("rdata_a", 32'(rdata_a), 32'(e)); end
    end
    if (rvalid_b === 1'b1) begin
      if (exp_b.size() == 0) check("rvalid_b_unexpected", 32'(rvalid_b), 32'd0);
      else begin e = exp_b.pop_front(); check("rdata_b", 32'(rdata_b), 32'(e)); end
    end
    if (gnt_a === 1'b1) gnt_log.push_back('{port: 1'b0, cyc: cyc});
    if (gnt_b === 1'b1) gnt_log.push_back('{port: 1'b1, cyc: cyc});
    if (busy === 1'b1) addr_log.push_back(mem_addr);
    if (mem_we === 1'b1) begin we_cnt++; we_cyc = cyc; end
  end

  // ------------------------------------------------------------------ tasks
  // Drive one request, queue its expected read bytes, hold until gnt, release.
  task automatic do_req(input bit port, input bit we, input logic [11:0] addr,
                        input logic [3:0] len, input logic [7:0] wdata,
                        output int t_req, output int t_gnt);
    logic [11:0] a;
    bit seen;
    int waited;
    if (we) ref_mem[addr] = wdata;
    else begin
      for (int k = 0; k <= int'(len); k++) begin
        a = addr + 12'(k);
        if (port) exp_b.push_back(ref_mem[a]);
        else      exp_a.push_back(ref_mem[a]);
      end
    end
    if (port) begin req_b = 1'b1; we_b = we; addr_b = addr; len_b = len; wdata_b = wdata; end
    else      begin req_a = 1'b1; we_a = we; addr_a = addr; len_a = len; wdata_a = wdata; end
    t_req = cyc;
    t_gnt = -1;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 50) begin
      @(negedge clk);
      if ((port ? gnt_b : gnt_a) === 1'b1) begin seen = 1'b1; t_gnt = cyc; end
      else begin @(posedge clk); #1; waited++; end
    end
    check(port ? "gnt_b_seen" : "gnt_a_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    if (port) req_b = 1'b0; else req_a = 1'b0;
  endtask

  // Wait (bounded) for outstanding beats to drain, then settle two cycles.
  task automatic drain();
    int w = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || busy !== 1'b0) && w < 64) begin
      @(negedge clk);
      w++;
    end
    check("drain_exp_a", 32'(exp_a.size()), 32'd0);
    check("drain_exp_b", 32'(exp_b.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    int t_req, t_gnt, t_w, ta1, ga1, tb1, gb1, rv_before, fa, fb;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_gnt_a",     32'(gnt_a),     32'd0);
    check("rst_gnt_b",     32'(gnt_b),     32'd0);
    check("rst_rvalid_a",  32'(rvalid_a),  32'd0);
    check("rst_rvalid_b",  32'(rvalid_b),  32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(posedge clk); #1;

    // Single read: A 0x200 len=1 -> 0x12, 0x34
    gnt_log.delete(); rva_cyc.delete(); we_cnt = 0;
    do_req(1'b0, 1'b0, 12'h200, 4'd1, 8'h00, t_req, t_gnt);
    drain();
    check("single_gnt_count",  32'(gnt_log.size()), 32'd1);
    check("single_gnt_lat",    32'(t_gnt),          32'(t_req + 1));
    check("single_rv_count",   32'(rva_cyc.size()), 32'd2);
    check("single_rv0_lat",    32'(rva_cyc[0]),     32'(t_req + 2));
    check("single_rv1_lat",    32'(rva_cyc[1]),     32'(t_req + 3));
    check("single_no_we",      32'(we_cnt),         32'd0);

    // Sprite burst wrapping past the top of memory: B 0xFFE len=3
    addr_log.delete();
    do_req(1'b1, 1'b0, 12'hFFE, 4'd3, 8'h00, t_req, t_gnt);
    drain();
    check("wrap_addr_count", 32'(addr_log.size()), 32'd4);
    check("wrap_addr0", 32'(addr_log[0]), 32'h FFE);
    check("wrap_addr1", 32'(addr_log[1]), 32'h FFF);
    check("wrap_addr2", 32'(addr_log[2]), 32'h000);
    check("wrap_addr3", 32'(addr_log[3]), 32'h001);

    // Contention: both ports request twice in a row (round-robin)
    gnt_log.delete();
    fork
      begin
        do_req(1'b0, 1'b0, 12'h500, 4'd1, 8'h00, ta1, ga1);
        do_req(1'b0, 1'b0, 12'h510, 4'd1, 8'h00, ta1, ga1);
      end
      begin
        do_req(1'b1, 1'b0, 12'h520, 4'd1, 8'h00, tb1, gb1);
        do_req(1'b1, 1'b0, 12'h530, 4'd1, 8'h00, tb1, gb1);
      end
    join
    drain();
    check("rr_gnt_count", 32'(gnt_log.size()), 32'd4);
    check("rr_order0", 32'(gnt_log[0].port), 32'd0);
    check("rr_order1", 32'(gnt_log[1].port), 32'd1);
    check("rr_order2", 32'(gnt_log[2].port), 32'd0);
    check("rr_order3", 32'(gnt_log[3].port), 32'd1);
    for (int i = 1; i < 4; i++)
      check("rr_no_bubble", 32'(gnt_log[i].cyc - gnt_log[i-1].cyc), 32'd2);

    // Write then read back
    we_cnt = 0;
    rv_before = rv_cnt_a;
    do_req(1'b0, 1'b1, 12'h300, 4'd5, 8'hAB, t_req, t_w);
    drain();
    check("wr_we_count", 32'(we_cnt), 32'd1);
    check("wr_we_cycle", 32'(we_cyc), 32'(t_w));
    check("wr_no_rvalid", 32'(rv_cnt_a), 32'(rv_before));
    do_req(1'b0, 1'b0, 12'h300, 4'd0, 8'h00, t_req, t_gnt);
    drain();
    check("wr_rd_beats", 32'(rv_cnt_a), 32'(rv_before + 1));

    // Same-port re-request: req released right after gnt -> one grant
    gnt_log.delete();
    do_req(1'b0, 1'b0, 12'h210, 4'd0, 8'h00, t_req, t_gnt);
    drain();
    check("rereq_single_gnt", 32'(gnt_log.size()), 32'd1);
    // req held one cycle past the gnt cycle -> a second grant two cycles later
    gnt_log.delete();
    exp_a.push_back(ref_mem[12'h220]);
    exp_a.push_back(ref_mem[12'h220]);
    req_a = 1'b1; we_a = 1'b0; addr_a = 12'h220; len_a = 4'd0;
    fa = 0;
    while (gnt_a !== 1'b1 && fa < 50) begin @(negedge clk); if (gnt_a !== 1'b1) begin @(posedge clk); #1; end fa++; end
    @(posedge clk); #1;   // gnt cycle over, req still high
    @(posedge clk); #1;
    req_a = 1'b0;
    drain();
    check("rereq_two_gnt", 32'(gnt_log.size()), 32'd2);
    check("rereq_gap", 32'(gnt_log[1].cyc - gnt_log[0].cyc), 32'd2);

    // Reset mid-burst: B len=15, rst high in the cycle of beat 5
    do_req(1'b1, 1'b0, 12'h400, 4'd15, 8'h00, t_req, t_gnt);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_rvalid_b", 32'(rvalid_b), 32'd0);
    check("midrst_mem_we",   32'(mem_we),   32'd0);
    check("midrst_beats_left", 32'(exp_b.size()), 32'd11);
    exp_b.delete();
    repeat (3) @(negedge clk);
    check("midrst_addr_hold", 32'(mem_addr), 32'd0);
    check("midrst_busy_hold", 32'(busy),     32'd0);
    @(posedge clk); #1;
    do_req(1'b0, 1'b0, 12'h200, 4'd1, 8'h00, t_req, t_gnt);
    drain();

    // Fixed priority: B never granted while A (len=3 bursts) keeps requesting
    fp_req_a = 1'b1; fp_req_b = 1'b1;
    fa = 0; fb = 0;
    repeat (30) begin
      @(negedge clk);
      if (fp_gnt_a === 1'b1) fa++;
      if (fp_gnt_b === 1'b1) fb++;
    end
    check("fp_b_starved", 32'(fb), 32'd0);
    check("fp_a_active",  32'(fa >= 6), 32'd1);
    @(posedge clk); #1 fp_req_a = 1'b0;
    fb = 0;
    repeat (10) begin
      @(negedge clk);
      if (fp_gnt_b === 1'b1) fb++;
    end
    check("fp_b_after_release", 32'(fb > 0), 32'd1);
    fp_req_b = 1'b0;
    repeat (6) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
